// File: rtl/imm_gen_stage.sv
// Registered RISC-V immediate generator with a 2-entry valid/ready skid buffer and flush.
// Format comes either from imm_sel or from the instruction's opcode/funct3 (AUTO_DECODE=1).
module imm_gen_stage #(
    parameter int unsigned XLEN        = 32,
    parameter bit          AUTO_DECODE = 1'b0
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     instr,
    input  logic [2:0]      imm_sel,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] imm,
    output logic            fmt_err
);

    typedef enum logic [2:0] {
        FmtI     = 3'b000,
        FmtS     = 3'b001,
        FmtB     = 3'b010,
        FmtJ     = 3'b011,
        FmtU     = 3'b100,
        FmtZ     = 3'b101,
        FmtShamt = 3'b110,
        FmtBad   = 3'b111
    } imm_fmt_e;

    localparam logic [6:0] OpLoad   = 7'b0000011;
    localparam logic [6:0] OpJalr   = 7'b1100111;
    localparam logic [6:0] OpImm    = 7'b0010011;
    localparam logic [6:0] OpImm32  = 7'b0011011;
    localparam logic [6:0] OpSystem = 7'b1110011;
    localparam logic [6:0] OpStore  = 7'b0100011;
    localparam logic [6:0] OpBranch = 7'b1100011;
    localparam logic [6:0] OpJal    = 7'b1101111;
    localparam logic [6:0] OpLui    = 7'b0110111;
    localparam logic [6:0] OpAuipc  = 7'b0010111;

    logic [6:0]      opcode;
    logic [2:0]      funct3;
    logic            is_shift;
    imm_fmt_e        fmt;
    logic            shamt5;
    logic            sgn;
    logic [XLEN-1:0] new_imm;
    logic            new_err;

    assign opcode   = instr[6:0];
    assign funct3   = instr[14:12];
    assign sgn      = instr[31];
    assign is_shift = (funct3 == 3'b001) || (funct3 == 3'b101);

    // Format selection; shamt5 narrows the shift amount for RV32 and for the RV64 *W shifts.
    always_comb begin
        fmt    = imm_fmt_e'(imm_sel);
        shamt5 = (XLEN == 32);
        if (AUTO_DECODE) begin
            case (opcode)
                OpLoad, OpJalr: fmt = FmtI;
                OpImm:          fmt = is_shift ? FmtShamt : FmtI;
                OpImm32: begin
                    if (XLEN == 64) begin
                        fmt    = is_shift ? FmtShamt : FmtI;
                        shamt5 = 1'b1;
                    end else begin
                        fmt = FmtBad;
                    end
                end
                OpSystem:       fmt = funct3[2] ? FmtZ : FmtI;
                OpStore:        fmt = FmtS;
                OpBranch:       fmt = FmtB;
                OpJal:          fmt = FmtJ;
                OpLui, OpAuipc: fmt = FmtU;
                default:        fmt = FmtBad;
            endcase
        end
    end

    always_comb begin
        new_imm = '0;
        new_err = 1'b0;
        unique case (fmt)
            FmtI:     new_imm = {{(XLEN-12){sgn}}, instr[31:20]};
            FmtS:     new_imm = {{(XLEN-12){sgn}}, instr[31:25], instr[11:7]};
            FmtB:     new_imm = {{(XLEN-13){sgn}}, instr[31], instr[7], instr[30:25],
                                 instr[11:8], 1'b0};
            FmtJ:     new_imm = {{(XLEN-21){sgn}}, instr[31], instr[19:12], instr[20],
                                 instr[30:21], 1'b0};
            FmtU:     new_imm = {{(XLEN-31){sgn}}, instr[30:12], 12'b0};
            FmtZ:     new_imm = {{(XLEN-5){1'b0}}, instr[19:15]};
            FmtShamt: new_imm = {{(XLEN-6){1'b0}},
                                 (shamt5 ? {1'b0, instr[24:20]} : instr[25:20])};
            FmtBad:   new_err = 1'b1;
        endcase
    end

    logic            out_valid_q, out_valid_d;
    logic [XLEN-1:0] out_imm_q, out_imm_d;
    logic            out_err_q, out_err_d;
    logic            skid_valid_q, skid_valid_d;
    logic [XLEN-1:0] skid_imm_q, skid_imm_d;
    logic            skid_err_q, skid_err_d;
    logic            accept;
    logic            load_out;

    assign accept   = in_valid & ~skid_valid_q;
    assign load_out = ~out_valid_q | out_ready;

    // The skid entry is only ever occupied while the output register is valid.
    always_comb begin
        out_valid_d  = out_valid_q;
        out_imm_d    = out_imm_q;
        out_err_d    = out_err_q;
        skid_valid_d = skid_valid_q;
        skid_imm_d   = skid_imm_q;
        skid_err_d   = skid_err_q;
        if (flush) begin
            out_valid_d  = 1'b0;
            skid_valid_d = 1'b0;
        end else if (load_out) begin
            if (skid_valid_q) begin
                out_valid_d  = 1'b1;
                out_imm_d    = skid_imm_q;
                out_err_d    = skid_err_q;
                skid_valid_d = 1'b0;
            end else begin
                out_valid_d = accept;
                if (accept) begin
                    out_imm_d = new_imm;
                    out_err_d = new_err;
                end
            end
        end else if (accept) begin
            skid_valid_d = 1'b1;
            skid_imm_d   = new_imm;
            skid_err_d   = new_err;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q  <= 1'b0;
            out_imm_q    <= '0;
            out_err_q    <= 1'b0;
            skid_valid_q <= 1'b0;
            skid_imm_q   <= '0;
            skid_err_q   <= 1'b0;
        end else begin
            out_valid_q  <= out_valid_d;
            out_imm_q    <= out_imm_d;
            out_err_q    <= out_err_d;
            skid_valid_q <= skid_valid_d;
            skid_imm_q   <= skid_imm_d;
            skid_err_q   <= skid_err_d;
        end
    end

    assign in_ready  = ~skid_valid_q;
    assign out_valid = out_valid_q;
    assign imm       = out_imm_q;
    assign fmt_err   = out_err_q;

endmodule

// File: tb/tb_imm_gen_stage.sv
// Scoreboard bench for imm_gen_stage: RV32/imm_sel and RV64/auto-decode instances share one
// handshake; expected results are queued on accept and compared while valid.
module tb_imm_gen_stage;

    logic        clk;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic [31:0] instr;
    logic [2:0]  imm_sel;
    logic        out_ready;

    logic        in_ready32, out_valid32, fmt_err32;
    logic [31:0] imm32;
    logic        in_ready64, out_valid64, fmt_err64;
    logic [63:0] imm64;

    imm_gen_stage #(.XLEN(32), .AUTO_DECODE(1'b0)) u_dut32 (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready32),
        .instr     (instr),
        .imm_sel   (imm_sel),
        .out_valid (out_valid32),
        .out_ready (out_ready),
        .imm       (imm32),
        .fmt_err   (fmt_err32)
    );

    imm_gen_stage #(.XLEN(64), .AUTO_DECODE(1'b1)) u_dut64 (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready64),
        .instr     (instr),
        .imm_sel   (imm_sel),
        .out_valid (out_valid64),
        .out_ready (out_ready),
        .imm       (imm64),
        .fmt_err   (fmt_err64)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [64:0] e32;
        logic [64:0] e64;
    } exp_t;

    exp_t q[$];
    int   errors = 0;
    int   checks = 0;
    bit   acc;
    int   words;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    // Reference model: {fmt_err, imm} with imm masked to 32 bits when x64=0.
    function automatic logic [64:0] ref_imm(input logic [31:0] i, input logic [2:0] sel,
                                            input bit x64, input bit autod);
        logic signed [63:0] sx;
        logic [63:0] top, s25, v;
        logic [6:0]  op;
        logic [2:0]  f3, f;
        logic        err;
        bit          narrow;
        sx     = $signed(i);
        top    = sx >>> 31;
        s25    = sx >>> 25;
        op     = i[6:0];
        f3     = i[14:12];
        narrow = !x64;
        f      = sel;
        err    = 1'b0;
        if (autod) begin
            if (op == 7'h03 || op == 7'h67) f = 3'd0;
            else if (op == 7'h13) f = (f3 == 3'd1 || f3 == 3'd5) ? 3'd6 : 3'd0;
            else if (op == 7'h1B && x64) begin
                f      = (f3 == 3'd1 || f3 == 3'd5) ? 3'd6 : 3'd0;
                narrow = 1'b1;
            end
            else if (op == 7'h73) f = f3[2] ? 3'd5 : 3'd0;
            else if (op == 7'h23) f = 3'd1;
            else if (op == 7'h63) f = 3'd2;
            else if (op == 7'h6F) f = 3'd3;
            else if (op == 7'h37 || op == 7'h17) f = 3'd4;
            else f = 3'd7;
        end
        case (f)
            3'd0: v = sx >>> 20;
            3'd1: v = (s25 << 5) | 64'(i[11:7]);
            3'd2: v = (top << 12) | (64'(i[7]) << 11) | (64'(i[30:25]) << 5) |
                      (64'(i[11:8]) << 1);
            3'd3: v = (top << 20) | (64'(i[19:12]) << 12) | (64'(i[20]) << 11) |
                      (64'(i[30:21]) << 1);
            3'd4: v = sx & ~64'hFFF;
            3'd5: v = 64'(i[19:15]);
            3'd6: v = narrow ? 64'(i[24:20]) : 64'(i[25:20]);
            default: begin
                v   = 64'd0;
                err = 1'b1;
            end
        endcase
        if (!x64) v = v & 64'h0000_0000_FFFF_FFFF;
        return {err, v};
    endfunction

    task automatic check_outputs();
        check("out_valid32", 64'(out_valid32), 64'(q.size() > 0));
        check("in_ready32", 64'(in_ready32), 64'(q.size() < 2));
        check("out_valid64", 64'(out_valid64), 64'(q.size() > 0));
        check("in_ready64", 64'(in_ready64), 64'(q.size() < 2));
        if (q.size() > 0) begin
            check("imm32", 64'(imm32), q[0].e32[63:0]);
            check("err32", 64'(fmt_err32), 64'(q[0].e32[64]));
            check("imm64", imm64, q[0].e64[63:0]);
            check("err64", 64'(fmt_err64), 64'(q[0].e64[64]));
        end
    endtask

    // One cycle: compare outputs at negedge, drive inputs, advance the model to the next edge.
    task automatic step(input bit iv, input logic [31:0] ins, input logic [2:0] sel,
                        input bit ordy, input bit fl, input logic [64:0] e32,
                        input logic [64:0] e64, output bit accepted);
        bit   rdy;
        exp_t e;
        @(negedge clk);
        check_outputs();
        in_valid  = iv;
        instr     = ins;
        imm_sel   = sel;
        out_ready = ordy;
        flush     = fl;
        accepted  = 1'b0;
        if (fl) begin
            q.delete();
        end else begin
            rdy = (q.size() < 2);
            if (q.size() > 0 && ordy) void'(q.pop_front());
            if (iv && rdy) begin
                e.e32 = e32;
                e.e64 = e64;
                q.push_back(e);
                accepted = 1'b1;
            end
        end
    endtask

    task automatic step_ref(input bit iv, input logic [31:0] ins, input logic [2:0] sel,
                            input bit ordy, input bit fl, output bit accepted);
        step(iv, ins, sel, ordy, fl, ref_imm(ins, sel, 1'b0, 1'b0),
             ref_imm(ins, sel, 1'b1, 1'b1), accepted);
    endtask

    function automatic logic [31:0] rand_instr();
        logic [6:0] ops [11];
        logic [31:0] w;
        ops = '{7'h03, 7'h67, 7'h13, 7'h1B, 7'h73, 7'h23, 7'h63, 7'h6F, 7'h37, 7'h17, 7'h7F};
        w = $urandom;
        if ($urandom_range(0, 9) < 8) w[6:0] = ops[$urandom_range(0, 10)];
        return w;
    endfunction

    logic [31:0] d32_ins [8];
    logic [2:0]  d32_sel [8];
    logic [64:0] d32_exp [8];
    logic [31:0] d64_ins [4];
    logic [64:0] d64_exp [4];

    initial begin
        d32_ins = '{32'hFFF00093, 32'hFE20AE23, 32'hFE000CE3, 32'h8000006F,
                    32'h123450B7, 32'h3057D073, 32'h03F09093, 32'h12345678};
        d32_sel = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7};
        d32_exp = '{{1'b0, 64'hFFFFFFFF}, {1'b0, 64'hFFFFFFFC}, {1'b0, 64'hFFFFFFF8},
                    {1'b0, 64'hFFF00000}, {1'b0, 64'h12345000}, {1'b0, 64'h0000000F},
                    {1'b0, 64'h0000001F}, {1'b1, 64'h0}};
        d64_ins = '{32'h800000B7, 32'h03F09093, 32'h0000007F, 32'h3057D073};
        d64_exp = '{{1'b0, 64'hFFFFFFFF80000000}, {1'b0, 64'h000000000000003F},
                    {1'b1, 64'h0}, {1'b0, 64'h000000000000000F}};

        rst_n     = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b0;
        instr     = 32'd0;
        imm_sel   = 3'd0;
        out_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_out_valid32", 64'(out_valid32), 64'd0);
        check("rst_imm32", 64'(imm32), 64'd0);
        check("rst_err32", 64'(fmt_err32), 64'd0);
        check("rst_in_ready32", 64'(in_ready32), 64'd1);
        check("rst_out_valid64", 64'(out_valid64), 64'd0);
        check("rst_imm64", imm64, 64'd0);
        check("rst_in_ready64", 64'(in_ready64), 64'd1);
        rst_n = 1'b1;

        // Streamed formats, full throughput.
        for (int k = 0; k < 8; k++)
            step(1'b1, d32_ins[k], d32_sel[k], 1'b1, 1'b0, d32_exp[k],
                 ref_imm(d32_ins[k], d32_sel[k], 1'b1, 1'b1), acc);
        for (int k = 0; k < 4; k++)
            step(1'b1, d64_ins[k], 3'd0, 1'b1, 1'b0, ref_imm(d64_ins[k], 3'd0, 1'b0, 1'b0),
                 d64_exp[k], acc);
        repeat (2) step_ref(1'b0, 32'd0, 3'd0, 1'b1, 1'b0, acc);

        // Backpressure: A held, B in skid, C held upstream until space frees.
        step_ref(1'b1, 32'h00100093, 3'd0, 1'b0, 1'b0, acc);
        step_ref(1'b1, 32'h00200093, 3'd0, 1'b0, 1'b0, acc);
        repeat (2) step_ref(1'b1, 32'h00300093, 3'd0, 1'b0, 1'b0, acc);
        acc = 1'b0;
        for (int k = 0; k < 10 && !acc; k++)
            step_ref(1'b1, 32'h00300093, 3'd0, 1'b1, 1'b0, acc);
        check("c_accepted", 64'(acc), 64'd1);
        repeat (3) step_ref(1'b0, 32'd0, 3'd0, 1'b1, 1'b0, acc);

        // Flush with both entries full and a word offered in the same cycle.
        step_ref(1'b1, 32'h00400093, 3'd0, 1'b0, 1'b0, acc);
        step_ref(1'b1, 32'h00500093, 3'd0, 1'b0, 1'b0, acc);
        step_ref(1'b1, 32'h00600093, 3'd0, 1'b0, 1'b1, acc);
        repeat (3) step_ref(1'b0, 32'd0, 3'd0, 1'b1, 1'b0, acc);

        // Asynchronous reset between edges with data in flight.
        step_ref(1'b1, 32'h00700093, 3'd0, 1'b0, 1'b0, acc);
        step_ref(1'b1, 32'h00800093, 3'd0, 1'b0, 1'b0, acc);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("arst_out_valid32", 64'(out_valid32), 64'd0);
        check("arst_imm32", 64'(imm32), 64'd0);
        check("arst_in_ready32", 64'(in_ready32), 64'd1);
        check("arst_out_valid64", 64'(out_valid64), 64'd0);
        check("arst_imm64", imm64, 64'd0);
        check("arst_in_ready64", 64'(in_ready64), 64'd1);
        q.delete();
        in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        step_ref(1'b1, 32'hABC00093, 3'd0, 1'b1, 1'b0, acc);
        repeat (2) step_ref(1'b0, 32'd0, 3'd0, 1'b1, 1'b0, acc);

        // Random traffic against the model.
        words = 0;
        for (int cyc = 0; cyc < 60000 && words < 10000; cyc++) begin
            step_ref($urandom_range(0, 9) < 7, rand_instr(), 3'($urandom_range(0, 7)),
                     $urandom_range(0, 9) < 7, $urandom_range(0, 49) == 0, acc);
            if (acc) words++;
        end
        check("random_words", 64'(words >= 10000), 64'd1);
        repeat (3) step_ref(1'b0, 32'd0, 3'd0, 1'b1, 1'b0, acc);
        @(negedge clk);
        check_outputs();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
